// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the fpadd writeback stage.
package fp_wb_pkg;

  localparam int unsigned WB_W = 64;

  // Bit positions inside the 5-bit IEEE exception flag vector.
  localparam int unsigned FLG_NV = 4;
  localparam int unsigned FLG_DZ = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  localparam logic [63:0] CANON_NAN64 = 64'h7FF8000000000000;

  typedef struct packed {
    logic [WB_W-1:0] result;
    logic [4:0]      flags;
    logic            denorm;
    logic [4:0]      tag;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } wb_state_t;

  // Exponent all-ones with a nonzero mantissa.
  function automatic logic is_nan64(logic [63:0] v);
    return (&v[62:52]) && (|v[51:0]);
  endfunction

endpackage

// File: rtl/fp_nan_canon.sv
// Replaces any f64 NaN with the canonical quiet NaN; other values pass unchanged.
module fp_nan_canon
  import fp_wb_pkg::*;
(
  input  logic [63:0] result_i,
  output logic [63:0] result_o
);

  // Pure select; flags are untouched by canonicalisation.
  always_comb begin
    result_o = is_nan64(result_i) ? CANON_NAN64 : result_i;
  end

endmodule

// File: rtl/fp_result_wb.sv
// Writeback stage behind fpadd: 2-entry skid buffer, sticky fflags, retire counter.
// Optional build macro FPWB_NAN_CANON_EN canonicalises NaN results on capture.
module fp_result_wb
  import fp_wb_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [4:0]       in_flags,
  input  logic             in_denorm,
  input  logic [4:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_flags,
  output logic             out_denorm,
  output logic [4:0]       out_tag,
  output logic [4:0]       fflags,
  input  logic             fflags_we,
  input  logic [4:0]       fflags_wdata,
  output logic [CNT_W-1:0] retired
);

  wb_state_t        state_q, state_d;
  wb_entry_t        head_q, head_d, tail_q, tail_d, cap;
  logic [4:0]       fflags_q, fflags_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [WB_W-1:0]  in_res64, cap_result;
  logic             push, pop;

  assign in_res64 = WB_W'(in_result);

`ifdef FPWB_NAN_CANON_EN
  fp_nan_canon u_nan_canon (
    .result_i (in_res64),
    .result_o (cap_result)
  );
`else
  assign cap_result = in_res64;
`endif

  // Entry captured from fpadd on an input transfer.
  always_comb begin
    cap = '{result: cap_result, flags: in_flags, denorm: in_denorm, tag: in_tag};
  end

  // Handshakes decode from the registered state only; no out_ready -> in_ready path.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next state and entry movement; head is always the oldest entry.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = cap;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = cap;
        end else if (push) begin
          tail_d  = cap;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Sticky flags collect on acceptance; a software write replaces the old value first.
  always_comb begin
    fflags_d  = (fflags_we ? fflags_wdata : fflags_q) | (push ? in_flags : 5'b0);
    retired_d = retired_q + CNT_W'(pop);
  end

  // Buffer state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Entry storage; cleared on reset so data outputs read zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // fflags and retire counter; reset wins over any same-cycle transfer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fflags_q  <= '0;
      retired_q <= '0;
    end else begin
      fflags_q  <= fflags_d;
      retired_q <= retired_d;
    end
  end

  assign out_result = WIDTH'(head_q.result);
  assign out_flags  = head_q.flags;
  assign out_denorm = head_q.denorm;
  assign out_tag    = head_q.tag;
  assign fflags     = fflags_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_fp_result_wb.sv
// Self-checking bench for fp_result_wb: directed table, streaming, random, reset corner.
module tb_fp_result_wb;

  localparam int unsigned CW = 4;
`ifdef FPWB_NAN_CANON_EN
  localparam bit CANON = 1'b1;
`else
  localparam bit CANON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, in_denorm, out_valid, out_ready, out_denorm, fflags_we;
  logic [63:0]   in_result, out_result;
  logic [4:0]    in_flags, in_tag, out_flags, out_tag, fflags, fflags_wdata;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  fp_result_wb #(.WIDTH(64), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_denorm    (in_denorm),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_denorm   (out_denorm),
    .out_tag      (out_tag),
    .fflags       (fflags),
    .fflags_we    (fflags_we),
    .fflags_wdata (fflags_wdata),
    .retired      (retired)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: a plain queue of accepted operations.
  typedef struct {
    logic [63:0] r;
    logic [4:0]  f;
    logic        d;
    logic [4:0]  t;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  m_ff;
  int unsigned m_ret;

  function automatic logic [63:0] ref_canon(input logic [63:0] v);
    if (CANON && v[62:52] == 11'h7FF && v[51:0] != 52'd0) return 64'h7FF8000000000000;
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model, clock, then settle 1 time unit.
  task automatic cyc(input logic iv, input logic ordy, input logic [63:0] res,
                     input logic [4:0] flg, input logic den, input logic [4:0] tag,
                     input logic we, input logic [4:0] wd);
    bit   psh, pp;
    ent_t e;
    in_valid = iv; out_ready = ordy; in_result = res; in_flags = flg;
    in_denorm = den; in_tag = tag; fflags_we = we; fflags_wdata = wd;
    psh  = iv && (mq.size() < 2);
    pp   = ordy && (mq.size() > 0);
    m_ff = (we ? wd : m_ff) | (psh ? flg : 5'd0);
    if (pp) begin
      void'(mq.pop_front());
      m_ret++;
    end
    if (psh) begin
      e.r = ref_canon(res); e.f = flg; e.d = den; e.t = tag;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string ph);
    chk({ph, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    chk({ph, ".in_ready"}, 64'(in_ready), 64'(mq.size() < 2));
    chk({ph, ".fflags"}, 64'(fflags), 64'(m_ff));
    chk({ph, ".retired"}, 64'(retired), 64'(m_ret % (1 << CW)));
    if (mq.size() > 0) begin
      chk({ph, ".out_result"}, out_result, mq[0].r);
      chk({ph, ".out_flags"}, 64'(out_flags), 64'(mq[0].f));
      chk({ph, ".out_denorm"}, 64'(out_denorm), 64'(mq[0].d));
      chk({ph, ".out_tag"}, 64'(out_tag), 64'(mq[0].t));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(1'b1, 1'b1, 64'h1234, 5'h1F, 1'b1, 5'd9, 1'b1, 5'h1F);
    mq.delete();
    m_ff  = '0;
    m_ret = 0;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        iv, ordy;
    logic [63:0] res;
    logic [4:0]  flg, tag;
    logic        we;
    logic [4:0]  wd;
    logic        e_ov, e_ir;
    logic [63:0] e_res;
    logic [4:0]  e_tag, e_ff;
    int          e_ret;
  } vec_t;

  function automatic vec_t mk(logic iv, logic ordy, logic [63:0] res, logic [4:0] flg,
                              logic [4:0] tag, logic we, logic [4:0] wd, logic e_ov,
                              logic e_ir, logic [63:0] e_res, logic [4:0] e_tag,
                              logic [4:0] e_ff, int e_ret);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.res = res; v.flg = flg; v.tag = tag; v.we = we; v.wd = wd;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_res = e_res; v.e_tag = e_tag; v.e_ff = e_ff;
    v.e_ret = e_ret;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    logic [63:0] nan_in, nan_exp, r;
    nan_in  = 64'h7FF0000000000001;
    nan_exp = CANON ? 64'h7FF8000000000000 : 64'h7FF0000000000001;

    tbl[0]  = mk(1, 1, 64'hBFF0000000000000, 5'h01, 5'd1, 0, 0,
                 1, 1, 64'hBFF0000000000000, 5'd1, 5'h01, 0);
    tbl[1]  = mk(0, 1, 64'h0, 5'h00, 5'd0, 0, 0, 0, 1, 64'h0, 5'd0, 5'h01, 1);
    tbl[2]  = mk(1, 0, 64'h3FF0000000000000, 5'h04, 5'd2, 0, 0,
                 1, 1, 64'h3FF0000000000000, 5'd2, 5'h05, 1);
    tbl[3]  = mk(1, 0, 64'h4000000000000000, 5'h03, 5'd3, 0, 0,
                 1, 0, 64'h3FF0000000000000, 5'd2, 5'h07, 1);
    tbl[4]  = mk(1, 0, 64'h4008000000000000, 5'h10, 5'd4, 0, 0,
                 1, 0, 64'h3FF0000000000000, 5'd2, 5'h07, 1);
    tbl[5]  = mk(0, 1, 64'h0, 5'h00, 5'd0, 0, 0, 1, 1, 64'h4000000000000000, 5'd3, 5'h07, 2);
    tbl[6]  = mk(0, 1, 64'h0, 5'h00, 5'd0, 0, 0, 0, 1, 64'h0, 5'd0, 5'h07, 3);
    tbl[7]  = mk(1, 0, 64'hC000000000000000, 5'h10, 5'd5, 1, 5'h00,
                 1, 1, 64'hC000000000000000, 5'd5, 5'h10, 3);
    tbl[8]  = mk(0, 1, 64'h0, 5'h00, 5'd0, 0, 0, 0, 1, 64'h0, 5'd0, 5'h10, 4);
    tbl[9]  = mk(1, 0, nan_in, 5'h00, 5'd6, 0, 0, 1, 1, nan_exp, 5'd6, 5'h10, 4);
    tbl[10] = mk(1, 1, 64'h3FE0000000000000, 5'h00, 5'd7, 0, 0,
                 1, 1, 64'h3FE0000000000000, 5'd7, 5'h10, 5);
    tbl[11] = mk(0, 1, 64'h0, 5'h00, 5'd0, 0, 0, 0, 1, 64'h0, 5'd0, 5'h10, 6);

    // Reset state.
    do_reset();
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.fflags", 64'(fflags), 64'd0);
    chk("rst.retired", 64'(retired), 64'd0);
    chk("rst.out_result", out_result, 64'd0);
    chk("rst.out_tag", 64'(out_tag), 64'd0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].iv, tbl[i].ordy, tbl[i].res, tbl[i].flg, 1'b0, tbl[i].tag, tbl[i].we,
          tbl[i].wd);
      chk($sformatf("tbl%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d.in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d.fflags", i), 64'(fflags), 64'(tbl[i].e_ff));
      chk($sformatf("tbl%0d.retired", i), 64'(retired), 64'(tbl[i].e_ret));
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d.out_result", i), out_result, tbl[i].e_res);
        chk($sformatf("tbl%0d.out_tag", i), 64'(out_tag), 64'(tbl[i].e_tag));
      end
    end

    // Streaming: 100 back-to-back ops, one output per cycle.
    for (int i = 0; i < 100; i++) begin
      r = {$urandom, $urandom};
      cyc(1'b1, 1'b1, r, 5'($urandom), 1'($urandom), 5'(i), 1'b0, 5'd0);
      check_model("stream");
      chk("stream.no_bubble", 64'(out_valid), 64'd1);
    end
    cyc(1'b0, 1'b1, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    check_model("drain");

    // Random traffic with occasional software writes and NaN/Inf inputs.
    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom};
      if ($urandom_range(3) == 0) r[62:52] = 11'h7FF;
      if ($urandom_range(7) == 0) r[51:0] = '0;
      cyc(1'($urandom), ($urandom_range(3) != 0), r, 5'($urandom_range(31) & 5'h15),
          1'($urandom), 5'($urandom), ($urandom_range(15) == 0), 5'($urandom));
      check_model("rand");
    end

    // Reset while FULL with a same-cycle input and output offered.
    cyc(1'b1, 1'b0, 64'hAAAA, 5'h02, 1'b0, 5'd1, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 64'hBBBB, 5'h08, 1'b0, 5'd2, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 64'hCCCC, 5'h01, 1'b0, 5'd3, 1'b0, 5'd0);
    check_model("fill");
    chk("full.in_ready", 64'(in_ready), 64'd0);
    do_reset();
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    chk("midrst.fflags", 64'(fflags), 64'd0);
    chk("midrst.retired", 64'(retired), 64'd0);

    // Operation after reset behaves normally.
    cyc(1'b1, 1'b0, 64'hBFF0000000000000, 5'h01, 1'b1, 5'd4, 1'b0, 5'd0);
    check_model("post");
    cyc(1'b0, 1'b1, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    check_model("post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
